burst_ram_arbiter: RTL and testbench

Two-port arbiter that shares one `burst_ram` command/data interface between two requesters: port 0 is the `ramio` cache and port 1 is a secondary master such as a flash-to-RAM loader or DMA. It grants whole bursts using round-robin, drives the RAM's command and write-data lines from the granted port, and routes read-burst data back to that port only. It sits between the requesters and `burst_ram` (or the PSRAM IP) and owns the RAM until each burst completes.

---
 rtl/burst_ram_arbiter_if.sv | 56 +++++
 rtl/burst_ram_arbiter.sv | 120 ++++++++++++
 tb/tb_burst_ram_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/burst_ram_arbiter_if.sv
// Requester and burst RAM signal bundle for burst_ram_arbiter.
// slave is the arbiter's view; master drives requests and the RAM side.
interface burst_ram_arbiter_if #(
  parameter int AddressBitWidth = 11
);
  logic                       p0_req;
  logic                       p0_cmd;
  logic [AddressBitWidth-1:0] p0_addr;
  logic [63:0]                p0_wr_data;
  logic [7:0]                 p0_data_mask;
  logic                       p0_ack;
  logic [63:0]                p0_rd_data;
  logic                       p0_rd_data_valid;

  logic                       p1_req;
  logic                       p1_cmd;
  logic [AddressBitWidth-1:0] p1_addr;
  logic [63:0]                p1_wr_data;
  logic [7:0]                 p1_data_mask;
  logic                       p1_ack;
  logic [63:0]                p1_rd_data;
  logic                       p1_rd_data_valid;

  logic                       br_cmd;
  logic                       br_cmd_en;
  logic [AddressBitWidth-1:0] br_addr;
  logic [63:0]                br_wr_data;
  logic [7:0]                 br_data_mask;
  logic [63:0]                br_rd_data;
  logic                       br_rd_data_valid;
  logic                       br_busy;

  modport slave (
    input  p0_req, p0_cmd, p0_addr,
    input  p0_wr_data, p0_data_mask,
    output p0_ack, p0_rd_data, p0_rd_data_valid,
    input  p1_req, p1_cmd, p1_addr,
    input  p1_wr_data, p1_data_mask,
    output p1_ack, p1_rd_data, p1_rd_data_valid,
    output br_cmd, br_cmd_en, br_addr,
    output br_wr_data, br_data_mask,
    input  br_rd_data, br_rd_data_valid, br_busy
  );

  modport master (
    output p0_req, p0_cmd, p0_addr,
    output p0_wr_data, p0_data_mask,
    input  p0_ack, p0_rd_data, p0_rd_data_valid,
    output p1_req, p1_cmd, p1_addr,
    output p1_wr_data, p1_data_mask,
    input  p1_ack, p1_rd_data, p1_rd_data_valid,
    input  br_cmd, br_cmd_en, br_addr,
    input  br_wr_data, br_data_mask,
    output br_rd_data, br_rd_data_valid, br_busy
  );
endinterface

// File: rtl/burst_ram_arbiter.sv
// Round-robin two-port arbiter granting whole bursts of one burst RAM.
// The owning port keeps the RAM until its last word moves.
module burst_ram_arbiter #(
  parameter int AddressBitWidth = 11,
  parameter int BurstDataCount  = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  burst_ram_arbiter_if.slave  bus
);

  localparam int CntW =
    (BurstDataCount > 1) ? $clog2(BurstDataCount) : 1;
  localparam logic [CntW-1:0] CntLast =
    CntW'(BurstDataCount - 1);

  typedef enum logic [1:0] {
    Idle,
    Write,
    Read
  } state_t;

  state_t                     state;
  logic                       owner;
  logic                       last;
  logic [CntW-1:0]            cnt;
  logic                       cmd_en;
  logic                       cmd;
  logic [AddressBitWidth-1:0] addr;
  logic [7:0]                 mask;
  logic                       ack0;
  logic                       ack1;

  logic                       both;
  logic                       any_req;
  logic                       win;
  logic                       win_cmd;
  logic [AddressBitWidth-1:0] win_addr;
  logic [7:0]                 win_mask;
  logic                       last_word;

  assign both    = bus.p0_req & bus.p1_req;
  assign any_req = bus.p0_req | bus.p1_req;
  // On a tie the port that did not win last time goes next
  assign win     = both ? ~last : bus.p1_req;

  assign win_cmd  = win ? bus.p1_cmd : bus.p0_cmd;
  assign win_addr = win ? bus.p1_addr : bus.p0_addr;
  assign win_mask =
    win ? bus.p1_data_mask : bus.p0_data_mask;

  assign last_word = (cnt == CntLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= Idle;
      owner  <= 1'b0;
      last   <= 1'b1;
      cnt    <= '0;
      cmd_en <= 1'b0;
      cmd    <= 1'b0;
      addr   <= '0;
      mask   <= '0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
    end else begin
      cmd_en <= 1'b0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      unique case (state)
        Idle: begin
          if (!bus.br_busy && any_req) begin
            cmd_en <= 1'b1;
            cmd    <= win_cmd;
            addr   <= win_addr;
            mask   <= win_mask;
            ack0   <= ~win;
            ack1   <= win;
            owner  <= win;
            last   <= win;
            cnt    <= '0;
            state  <= win_cmd ? Write : Read;
          end
        end
        Write: begin
          cnt <= cnt + 1'b1;
          if (last_word) state <= Idle;
        end
        Read: begin
          if (bus.br_rd_data_valid) begin
            cnt <= cnt + 1'b1;
            if (last_word) state <= Idle;
          end
        end
        default: state <= Idle;
      endcase
    end
  end

  assign bus.br_cmd_en    = cmd_en;
  assign bus.br_cmd       = cmd;
  assign bus.br_addr      = addr;
  assign bus.br_data_mask = mask;
  assign bus.p0_ack       = ack0;
  assign bus.p1_ack       = ack1;

  // Write data is live from the owner so word i lands on cycle i
  assign bus.br_wr_data =
    (state != Write) ? 64'd0 :
    (owner ? bus.p1_wr_data : bus.p0_wr_data);

  assign bus.p0_rd_data = bus.br_rd_data;
  assign bus.p1_rd_data = bus.br_rd_data;

  assign bus.p0_rd_data_valid =
    bus.br_rd_data_valid & (state == Read) & ~owner;
  assign bus.p1_rd_data_valid =
    bus.br_rd_data_valid & (state == Read) & owner;

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed bench for burst_ram_arbiter with a small burst RAM model.
// Vector table for grant selection plus multi-cycle burst sequences.
module tb_burst_ram_arbiter;
  localparam int AW  = 11;
  localparam int BDC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  burst_ram_arbiter_if #(.AddressBitWidth(AW)) bus ();

  burst_ram_arbiter #(
    .AddressBitWidth(AW),
    .BurstDataCount (BDC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Burst RAM model: 6-cycle read latency, 4-word bursts
  logic [63:0]   mem [0:2047];
  logic [AW-1:0] wbase, rbase;
  int            widx, ridx, rwait;
  logic          wact, ract, m_valid, spur;
  logic [63:0]   m_data;

  assign bus.br_rd_data       = m_data;
  assign bus.br_rd_data_valid = m_valid | spur;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wact <= 1'b0; ract <= 1'b0; m_valid <= 1'b0;
      m_data <= '0; widx <= 0; ridx <= 0; rwait <= 0;
      wbase <= '0; rbase <= '0;
    end else begin
      m_valid <= 1'b0;
      if (bus.br_cmd_en && bus.br_cmd) begin
        mem[bus.br_addr] <= bus.br_wr_data;
        wbase <= bus.br_addr; widx <= 1; wact <= 1'b1;
      end else if (wact) begin
        mem[wbase + AW'(widx)] <= bus.br_wr_data;
        widx <= widx + 1;
        if (widx == BDC - 1) wact <= 1'b0;
      end
      if (bus.br_cmd_en && !bus.br_cmd) begin
        rbase <= bus.br_addr; ridx <= 0;
        rwait <= 6; ract <= 1'b1;
      end else if (ract) begin
        if (rwait > 1) rwait <= rwait - 1;
        else begin
          m_valid <= 1'b1;
          m_data <= mem[rbase + AW'(ridx)];
          ridx <= ridx + 1;
          if (ridx == BDC - 1) ract <= 1'b0;
        end
      end
    end
  end

  // Grant monitor
  int cyc = 0;
  int pair_bad = 0;
  int ack0_cnt = 0, ack1_cnt = 0, en_cnt = 0;
  int q_port[$];
  int q_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.p0_ack) begin
      q_port.push_back(0); q_cyc.push_back(cyc);
      ack0_cnt <= ack0_cnt + 1;
    end
    if (bus.p1_ack) begin
      q_port.push_back(1); q_cyc.push_back(cyc);
      ack1_cnt <= ack1_cnt + 1;
    end
    if (bus.br_cmd_en) en_cnt <= en_cnt + 1;
    if ((bus.p0_ack | bus.p1_ack) !== bus.br_cmd_en)
      pair_bad <= pair_bad + 1;
  end

  task automatic drive(input bit port, input bit req,
                       input bit cmd, input logic [AW-1:0] addr,
                       input logic [63:0] wd);
    if (!port) begin
      bus.p0_req = req; bus.p0_cmd = cmd;
      bus.p0_addr = addr; bus.p0_wr_data = wd;
    end else begin
      bus.p1_req = req; bus.p1_cmd = cmd;
      bus.p1_addr = addr; bus.p1_wr_data = wd;
    end
  endtask

  task automatic wait_ack(input bit port, output int lat);
    lat = -1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (port ? bus.p1_ack : bus.p0_ack) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic do_write(input bit port, input logic [AW-1:0] addr,
                          input logic [63:0] w [4], output int lat);
    drive(port, 1'b1, 1'b1, addr, w[0]);
    wait_ack(port, lat);
    drive(port, 1'b0, 1'b1, addr, w[0]);
    for (int i = 1; i < BDC; i++) begin
      @(negedge clk);
      drive(port, 1'b0, 1'b1, addr, w[i]);
    end
    @(negedge clk);
  endtask

  task automatic do_read(input bit port, input logic [AW-1:0] addr,
                         input logic [63:0] w [4], output int lat,
                         input string name);
    int n, other;
    n = 0; other = 0;
    drive(port, 1'b1, 1'b0, addr, 64'd0);
    wait_ack(port, lat);
    drive(port, 1'b0, 1'b0, addr, 64'd0);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (port ? bus.p1_rd_data_valid : bus.p0_rd_data_valid) begin
        if (n < BDC)
          chk($sformatf("%s_data%0d", name, n),
              port ? bus.p1_rd_data : bus.p0_rd_data, w[n]);
        n++;
      end
      if (port ? bus.p0_rd_data_valid : bus.p1_rd_data_valid)
        other++;
    end
    chk({name, "_valid_count"}, n, BDC);
    chk({name, "_other_valid"}, other, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cmd_en"}, bus.br_cmd_en, 0);
    chk({tag, "_cmd"}, bus.br_cmd, 0);
    chk({tag, "_addr"}, bus.br_addr, 0);
    chk({tag, "_mask"}, bus.br_data_mask, 0);
    chk({tag, "_wr_data"}, bus.br_wr_data, 0);
    chk({tag, "_ack0"}, bus.p0_ack, 0);
    chk({tag, "_ack1"}, bus.p1_ack, 0);
    chk({tag, "_valid0"}, bus.p0_rd_data_valid, 0);
    chk({tag, "_valid1"}, bus.p1_rd_data_valid, 0);
  endtask

  typedef struct {
    bit            p0;
    bit            p1;
    bit            busy;
    bit            a0;
    bit            a1;
    logic [AW-1:0] addr;
    logic [7:0]    mask;
  } vec_t;

  vec_t        tbl [10];
  logic [63:0] wa [4];
  logic [63:0] wb [4];
  int          lat, bad, a0, a1, e0;

  initial begin
    tbl[0] = '{1, 0, 0, 1, 0, 11'h040, 8'hA5};
    tbl[1] = '{0, 1, 0, 0, 1, 11'h050, 8'h5A};
    tbl[2] = '{1, 1, 0, 1, 0, 11'h040, 8'hA5};
    tbl[3] = '{1, 1, 0, 0, 1, 11'h050, 8'h5A};
    tbl[4] = '{1, 1, 1, 0, 0, 11'h000, 8'h00};
    tbl[5] = '{0, 0, 0, 0, 0, 11'h000, 8'h00};
    tbl[6] = '{0, 1, 0, 0, 1, 11'h050, 8'h5A};
    tbl[7] = '{1, 1, 0, 1, 0, 11'h040, 8'hA5};
    tbl[8] = '{1, 0, 0, 1, 0, 11'h040, 8'hA5};
    tbl[9] = '{1, 1, 0, 0, 1, 11'h050, 8'h5A};
    wa = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
           64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    wb = '{64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0002,
           64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0004};

    bus.br_busy = 1'b0;
    spur = 1'b0;
    bus.p0_data_mask = 8'hA5;
    bus.p1_data_mask = 8'h5A;
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Both ports held from reset: strict alternation, back to back
    q_port.delete(); q_cyc.delete();
    drive(0, 1, 1, 11'h100, 64'hAAAA);
    drive(1, 1, 1, 11'h200, 64'hBBBB);
    for (int i = 0; i < 80 && q_port.size() < 6; i++)
      @(negedge clk);
    drive(0, 0, 1, 11'h100, 64'hAAAA);
    drive(1, 0, 1, 11'h200, 64'hBBBB);
    chk("alt_count", q_port.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < q_port.size())
        chk($sformatf("alt_order%0d", i), q_port[i], i % 2);
    if (q_cyc.size() >= 2)
      chk("alt_gap", q_cyc[1] - q_cyc[0], BDC + 1);
    repeat (6) @(negedge clk);

    // Port 0 write burst
    a0 = ack0_cnt; a1 = ack1_cnt; e0 = en_cnt;
    do_write(0, 11'h010, wa, lat);
    chk("wr_latency", lat, 1);
    chk("wr_ack0_once", ack0_cnt - a0, 1);
    chk("wr_ack1_none", ack1_cnt - a1, 0);
    chk("wr_cmd_en_once", en_cnt - e0, 1);
    for (int i = 0; i < BDC; i++)
      chk($sformatf("ram_word%0d", i), mem[11'h010 + AW'(i)], wa[i]);

    // Port 1 reads it back
    do_read(1, 11'h010, wa, lat, "rd_p1");
    chk("rd_p1_latency", lat, 1);

    // RAM busy blocks issue
    @(negedge clk);
    bus.br_busy = 1'b1;
    drive(0, 1, 1, 11'h030, wb[0]);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.p0_ack | bus.p1_ack | bus.br_cmd_en) bad++;
    end
    chk("busy_blocks", bad, 0);
    bus.br_busy = 1'b0;
    @(negedge clk);
    chk("busy_ack", bus.p0_ack, 1);
    chk("busy_cmd_en", bus.br_cmd_en, 1);
    drive(0, 0, 1, 11'h030, wb[0]);
    for (int i = 1; i < BDC; i++) begin
      @(negedge clk);
      drive(0, 0, 1, 11'h030, wb[i]);
    end
    @(negedge clk);
    chk("busy_ram_first", mem[11'h030], wb[0]);
    chk("busy_ram_last", mem[11'h033], wb[3]);

    // Spurious valid in Idle
    spur = 1'b1;
    #1;
    chk("spur_valid0", bus.p0_rd_data_valid, 0);
    chk("spur_valid1", bus.p1_rd_data_valid, 0);
    @(negedge clk);
    spur = 1'b0;
    do_read(0, 11'h030, wb, lat, "rd_p0");
    chk("spur_then_latency", lat, 1);

    // Reset during read
    drive(1, 1, 0, 11'h010, 64'd0);
    wait_ack(1, lat);
    drive(1, 0, 0, 11'h010, 64'd0);
    chk("mid_rd_ack", lat, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_read(1, 11'h010, wa, lat, "rd_after_rst");
    chk("rd_after_rst_latency", lat, 1);

    // Grant selection vectors; arbiter last granted port 1 here
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.br_busy = tbl[i].busy;
      drive(0, tbl[i].p0, 1, 11'h040, 64'd0);
      drive(1, tbl[i].p1, 1, 11'h050, 64'd0);
      @(negedge clk);
      chk($sformatf("tbl%0d_ack0", i), bus.p0_ack, tbl[i].a0);
      chk($sformatf("tbl%0d_ack1", i), bus.p1_ack, tbl[i].a1);
      chk($sformatf("tbl%0d_cmd_en", i), bus.br_cmd_en,
          tbl[i].a0 | tbl[i].a1);
      if (tbl[i].a0 | tbl[i].a1) begin
        chk($sformatf("tbl%0d_addr", i), bus.br_addr, tbl[i].addr);
        chk($sformatf("tbl%0d_mask", i), bus.br_data_mask,
            tbl[i].mask);
        chk($sformatf("tbl%0d_cmd", i), bus.br_cmd, 1);
      end
      drive(0, 0, 1, 11'h040, 64'd0);
      drive(1, 0, 1, 11'h050, 64'd0);
      bus.br_busy = 1'b0;
      repeat (BDC) @(negedge clk);
    end

    chk("ack_with_cmd_en", pair_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
